sample_streamer: RTL and testbench

- Producer end of the en/x sample stream consumed by the iterative max-search circuit.
- Buffers W-bit samples written by a host, then on start emits exactly N_ITER samples, one per accepted cycle.
- Drives x with an en qualifier, honours a consumer ready stall, and flags completion, underrun and overflow.

---
 rtl/sample_streamer_pkg.sv | 9 +
 rtl/sample_streamer_if.sv | 27 ++
 rtl/sample_streamer_fifo.sv | 41 ++++
 rtl/sample_streamer.sv | 56 +++++
 tb/tb_sample_streamer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sample_streamer_pkg.sv
// sample_streamer_pkg: shared state encodings and counter width for the sample streamer
package sample_streamer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
    localparam int CNT_W = 16;
endpackage

// File: rtl/sample_streamer_if.sv
// sample_streamer_if: host write port, run control and en/x stream bundled for the streamer
interface sample_streamer_if #(
    parameter int W       = 32,
    parameter int DEPTH_W = 7
);
    logic               wr_en;
    logic [W-1:0]       wr_data;
    logic               full;
    logic [DEPTH_W:0]   level;
    logic               start;
    logic               ready;
    logic               en;
    logic [W-1:0]       x;
    logic               busy;
    logic               done;
    logic               underrun;
    logic               overflow;
    logic               clr_flags;
    modport master (
        input  wr_en, wr_data, start, ready, clr_flags,
        output full, level, en, x, busy, done, underrun, overflow
    );
    modport slave (
        output wr_en, wr_data, start, ready, clr_flags,
        input  full, level, en, x, busy, done, underrun, overflow
    );
endinterface

// File: rtl/sample_streamer_fifo.sv
// sample_fifo: circular sample buffer with registered read data that holds between pops
module sample_fifo #(
    parameter int W       = 32,
    parameter int DEPTH_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       dout,
    output logic [DEPTH_W:0]   level,
    output logic               full,
    output logic               empty
);
    localparam int DEPTH = 2 ** DEPTH_W;
    logic [W-1:0]         mem [DEPTH];
    logic [DEPTH_W-1:0]   wr_ptr, rd_ptr;
    logic                 do_push, do_pop;
    assign full    = level == (DEPTH_W + 1)'(DEPTH);
    assign empty   = level == '0;
    // a write while full is refused even if a pop frees a slot this cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            level <= level + (DEPTH_W + 1)'(do_push) - (DEPTH_W + 1)'(do_pop);
        end
endmodule

// File: rtl/sample_streamer.sv
// sample_streamer: emits N_ITER buffered samples per run as a registered en/x stream with ready stall
module sample_streamer
    import sample_streamer_pkg::*;
#(
    parameter int W       = 32,
    parameter int DEPTH_W = 7,
    parameter int N_ITER  = 99
) (
    input logic clk,
    input logic rst_n,
    sample_streamer_if.master bus
);
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               empty, pop, last, go;
    logic               done_n, underrun_n, overflow_n;
    sample_fifo #(.W(W), .DEPTH_W(DEPTH_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (bus.x),
        .level (bus.level),
        .full  (bus.full),
        .empty (empty)
    );
    assign pop      = state == ST_STREAM && bus.ready && !empty;
    assign last     = pop && cnt == CNT_W'(N_ITER - 1);
    assign go       = bus.start && state != ST_STREAM;
    assign bus.busy = state == ST_STREAM;
    // flag sets win over clr_flags; a new run clears done
    always_comb begin
        state_n    = go ? ST_STREAM : last ? ST_DONE : state;
        cnt_n      = go ? '0 : pop ? cnt + 1'b1 : cnt;
        done_n     = last | (bus.done & ~go & ~bus.clr_flags);
        underrun_n = (bus.busy & bus.ready & empty) | (bus.underrun & ~bus.clr_flags);
        overflow_n = (bus.wr_en & bus.full) | (bus.overflow & ~bus.clr_flags);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus.en       <= 1'b0;
            bus.done     <= 1'b0;
            bus.underrun <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bus.en       <= pop;
            bus.done     <= done_n;
            bus.underrun <= underrun_n;
            bus.overflow <= overflow_n;
        end
endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: directed checks of reset, streaming, backpressure, underrun, overflow/wrap and restart
module tb_sample_streamer;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          n_en   = 0;
    logic [31:0] exp_x  = '0;
    logic        bp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        bp_en  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] bp_x   [7] = '{32'hA0, 32'hA0, 32'hA0, 32'hB0, 32'hC0, 32'hC0, 32'hD0};
    logic [31:0] bp_d   [4] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};

    always #5 clk = ~clk;

    sample_streamer_if #(.W(32), .DEPTH_W(7)) a ();
    sample_streamer_if #(.W(32), .DEPTH_W(7)) b ();

    sample_streamer #(.W(32), .DEPTH_W(7), .N_ITER(99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );
    sample_streamer #(.W(32), .DEPTH_W(7), .N_ITER(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        if (a.en) begin
            chk("x_order", a.x, exp_x);
            exp_x++;
            n_en++;
        end
    endtask

    task automatic do_reset();
        {a.wr_en, a.start, a.ready, a.clr_flags} = '0;
        {b.wr_en, b.start, b.ready, b.clr_flags} = '0;
        a.wr_data = '0;
        b.wr_data = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [31:0] d);
        a.wr_en   = 1'b1;
        a.wr_data = d;
        tick();
        a.wr_en   = 1'b0;
    endtask

    task automatic go();
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_en", a.en, 0);
        chk("rst_x", a.x, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_done", a.done, 0);
        chk("rst_level", a.level, 0);
        chk("rst_full", a.full, 0);

        // reset mid-run
        for (int i = 0; i < 5; i++) wr(100 + i);
        a.ready = 1'b1;
        go();
        n_en  = 0;
        exp_x = 100;
        for (int i = 0; i < 10 && n_en < 2; i++) step();
        chk("mid_en_count", n_en, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_en", a.en, 0);
        chk("mid_x", a.x, 0);
        chk("mid_busy", a.busy, 0);
        chk("mid_done", a.done, 0);
        chk("mid_underrun", a.underrun, 0);
        chk("mid_overflow", a.overflow, 0);
        chk("mid_level", a.level, 0);
        chk("mid_full", a.full, 0);
        tick();
        rst_n = 1'b1;
        tick();
        go();
        n_en = 0;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_no_en", n_en, 0);
        chk("post_rst_underrun", a.underrun, 1);
        chk("post_rst_busy", a.busy, 1);

        // basic run: 99 consecutive pulses one cycle after the first pop
        do_reset();
        for (int i = 1; i <= 99; i++) wr(i);
        chk("basic_level", a.level, 99);
        a.ready = 1'b1;
        go();
        for (int i = 1; i <= 99; i++) begin
            tick();
            chk("basic_en", a.en, 1);
            chk("basic_x", a.x, i);
        end
        chk("basic_done", a.done, 1);
        chk("basic_busy", a.busy, 0);
        chk("basic_level_end", a.level, 0);
        tick();
        chk("basic_en_off", a.en, 0);
        chk("basic_x_hold", a.x, 99);
        chk("basic_done_hold", a.done, 1);

        // restart with clr_flags and start together; start mid-run ignored
        for (int i = 100; i <= 198; i++) wr(i);
        chk("rs_level", a.level, 99);
        a.clr_flags = 1'b1;
        a.start     = 1'b1;
        tick();
        a.clr_flags = 1'b0;
        a.start     = 1'b0;
        chk("rs_done_clr", a.done, 0);
        chk("rs_busy", a.busy, 1);
        exp_x = 100;
        n_en  = 0;
        for (int i = 0; i < 10; i++) step();
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        for (int i = 0; i < 150 && !a.done; i++) step();
        chk("rs_done", a.done, 1);
        chk("rs_count", n_en, 99);
        for (int i = 0; i < 3; i++) step();
        chk("rs_no_extra", n_en, 99);

        // backpressure on the N_ITER=4 instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b.wr_en   = 1'b1;
            b.wr_data = bp_d[i];
            tick();
        end
        b.wr_en = 1'b0;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            b.ready = bp_rdy[k];
            tick();
            chk("bp_en", b.en, bp_en[k]);
            chk("bp_x", b.x, bp_x[k]);
        end
        chk("bp_done", b.done, 1);
        chk("bp_level", b.level, 0);
        b.ready = 1'b0;

        // underrun stalls the run, late writes complete it
        do_reset();
        exp_x = 1;
        n_en  = 0;
        for (int i = 1; i <= 3; i++) wr(i);
        a.ready = 1'b1;
        go();
        for (int i = 0; i < 6; i++) step();
        chk("ur_count", n_en, 3);
        chk("ur_flag", a.underrun, 1);
        chk("ur_busy", a.busy, 1);
        chk("ur_done", a.done, 0);
        for (int i = 4; i <= 99; i++) begin
            a.wr_en   = 1'b1;
            a.wr_data = i;
            step();
        end
        a.wr_en = 1'b0;
        for (int i = 0; i < 10 && !a.done; i++) step();
        chk("ur_done_end", a.done, 1);
        chk("ur_total", n_en, 99);

        // overflow, flag priority and pointer wrap
        do_reset();
        for (int i = 0; i < 128; i++) wr(1000 + i);
        chk("ov_full", a.full, 1);
        chk("ov_level", a.level, 128);
        chk("ov_clean", a.overflow, 0);
        wr(32'hDEAD);
        chk("ov_flag", a.overflow, 1);
        chk("ov_level_hold", a.level, 128);
        a.clr_flags = 1'b1;
        wr(32'hDEAD);
        chk("ov_set_wins", a.overflow, 1);
        tick();
        a.clr_flags = 1'b0;
        chk("ov_cleared", a.overflow, 0);
        a.ready = 1'b1;
        exp_x = 1000;
        n_en  = 0;
        go();
        for (int i = 0; i < 150 && !a.done; i++) step();
        chk("wrap1_count", n_en, 99);
        chk("wrap1_level", a.level, 29);
        for (int i = 0; i < 99; i++) wr(1128 + i);
        chk("wrap_refill", a.level, 128);
        n_en = 0;
        go();
        for (int i = 0; i < 150 && !a.done; i++) step();
        chk("wrap2_count", n_en, 99);
        chk("wrap2_done", a.done, 1);
        chk("wrap2_level", a.level, 29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
